// File: rtl/matrix_stream_loader_if.sv
// Byte stream, base-address grant and matrix RAM write bundle of the matrix loader.
// The master side belongs to the UART/control FSM and the slave side to the loader.
interface matrix_stream_loader_if #(
  parameter int DW = 8,
  parameter int AW = 9
);
  logic          en;
  logic          gen_mode;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW-1:0] base_addr;
  logic          addr_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          dims_valid;
  logic [2:0]    dim_m;
  logic [2:0]    dim_n;
  logic [1:0]    mat_idx;
  logic          done;
  logic          err;

  modport master (
    output en, gen_mode, rx_data, rx_valid, base_addr, addr_ready,
    input  wr_en, wr_addr, wr_data, dims_valid, dim_m, dim_n, mat_idx, done, err
  );

  modport slave (
    input  en, gen_mode, rx_data, rx_valid, base_addr, addr_ready,
    output wr_en, wr_addr, wr_data, dims_valid, dim_m, dim_n, mat_idx, done, err
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// ASCII "M N [K] e0 e1 ..." parser that loads one typed matrix, or K LFSR-generated
// matrices, into matrix RAM at an externally granted base address.
module matrix_stream_loader #(
  parameter int          MAX_DIM   = 5,
  parameter int          MAX_GEN   = 2,
  parameter int          ELEM_MIN  = 0,
  parameter int          ELEM_MAX  = 9,
  parameter int          DW        = 8,
  parameter int          AW        = 9,
  parameter int          TIMEOUT   = 25_000_000,
  parameter logic [31:0] LFSR_SEED = 32'hACE1
) (
  input logic                   clk,
  input logic                   rst_n,
  matrix_stream_loader_if.slave bus
);

  localparam int ABS_MIN = (ELEM_MIN < 0) ? -ELEM_MIN : ELEM_MIN;
  localparam int ABS_MAX = (ELEM_MAX < 0) ? -ELEM_MAX : ELEM_MAX;
  localparam int LIM_E   = (ABS_MIN > ABS_MAX) ? ABS_MIN : ABS_MAX;
  localparam int LIMIT   = (LIM_E > MAX_DIM) ? LIM_E : MAX_DIM;
  localparam int RANGE   = ELEM_MAX - ELEM_MIN + 1;
  localparam int IW      = $clog2(MAX_DIM * MAX_DIM + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_RX_M      = 4'd0,
    S_RX_N      = 4'd1,
    S_RX_CNT    = 4'd2,
    S_WAIT_ADDR = 4'd3,
    S_CLEAR     = 4'd4,
    S_ELEM      = 4'd5,
    S_GEN       = 4'd6,
    S_FLUSH     = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t        r_state;
  logic [31:0]   r_acc;
  logic          r_neg;
  logic          r_bad;
  logic          r_has;
  logic          r_dig;
  logic [2:0]    r_dim_m;
  logic [2:0]    r_dim_n;
  logic [1:0]    r_k;
  logic [1:0]    r_mat_idx;
  logic [AW-1:0] r_base;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_to;
  logic [31:0]   r_lfsr;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic          r_dims_valid;
  logic          r_done;
  logic          r_done_sent;
  logic          r_err;

  logic               w_is_eol;
  logic               w_is_delim;
  logic               w_is_digit;
  logic               w_is_minus;
  logic               w_tok_state;
  logic               w_tok_end;
  logic               w_dim_ok;
  logic               w_cnt_ok;
  logic               w_elem_ok;
  logic               w_idx_last;
  logic               w_timeout;
  logic               w_lfsr_fb;
  logic [31:0]        w_acc_next;
  logic [31:0]        w_mn;
  logic signed [31:0] w_val;
  logic [DW-1:0]      w_rand;

  // Byte classification, token verdicts and generator data
  always_comb begin
    w_is_eol    = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    w_is_delim  = w_is_eol || (bus.rx_data == 8'h20);
    w_is_digit  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    w_is_minus  = (bus.rx_data == 8'h2D);
    w_acc_next  = (r_acc * 32'd10) + {28'd0, bus.rx_data[3:0]};
    w_val       = r_neg ? -$signed(r_acc) : $signed(r_acc);
    w_tok_state = (r_state == S_RX_M) || (r_state == S_RX_N) ||
                  (r_state == S_RX_CNT) || (r_state == S_ELEM);
    w_tok_end   = bus.rx_valid && w_tok_state && w_is_delim && r_has;
    w_dim_ok    = r_dig && !r_bad && !r_neg && (r_acc >= 32'd1) && (r_acc <= 32'(MAX_DIM));
    w_cnt_ok    = r_dig && !r_bad && !r_neg && (r_acc >= 32'd1) && (r_acc <= 32'(MAX_GEN));
    w_elem_ok   = r_dig && !r_bad && (w_val >= ELEM_MIN) && (w_val <= ELEM_MAX);
    w_mn        = 32'(r_dim_m) * 32'(r_dim_n);
    w_idx_last  = (32'(r_idx) == (w_mn - 32'd1));
    w_timeout   = ((r_state == S_ELEM) || (r_state == S_FLUSH)) && !bus.rx_valid &&
                  (r_to == TW'(TIMEOUT - 1));
    w_lfsr_fb   = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1];
    w_rand      = DW'(ELEM_MIN + int'(r_lfsr % 32'(RANGE)));
  end

  // Free-running pattern source, independent of en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[30:0], w_lfsr_fb};
    end
  end

  // Idle counter, only meaningful while waiting on the user
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to <= '0;
    end else if (!bus.en || bus.rx_valid || ((r_state != S_ELEM) && (r_state != S_FLUSH))) begin
      r_to <= '0;
    end else if (r_to != TW'(TIMEOUT)) begin
      r_to <= r_to + 1'b1;
    end
  end

  // Token accumulator; saturates one above the largest legal magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 32'd0; r_neg <= 1'b0; r_bad <= 1'b0; r_has <= 1'b0; r_dig <= 1'b0;
    end else if (!bus.en || !w_tok_state || (bus.rx_valid && w_is_delim)) begin
      r_acc <= 32'd0; r_neg <= 1'b0; r_bad <= 1'b0; r_has <= 1'b0; r_dig <= 1'b0;
    end else if (bus.rx_valid) begin
      r_has <= 1'b1;
      if (w_is_digit) begin
        r_dig <= 1'b1;
        if (w_acc_next > 32'(LIMIT)) begin
          r_acc <= 32'(LIMIT + 1);
          r_bad <= 1'b1;
        end else begin
          r_acc <= w_acc_next;
        end
      end else if (w_is_minus && (r_state == S_ELEM) && !r_has) begin
        r_neg <= 1'b1;
      end else begin
        r_bad <= 1'b1;
      end
    end
  end

  // Main sequencer with registered RAM, handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RX_M;
      r_dim_m      <= 3'd0;
      r_dim_n      <= 3'd0;
      r_k          <= 2'd0;
      r_mat_idx    <= 2'd0;
      r_base       <= '0;
      r_idx        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_dims_valid <= 1'b0;
      r_done       <= 1'b0;
      r_done_sent  <= 1'b0;
      r_err        <= 1'b0;
    end else if (!bus.en) begin
      r_state      <= S_RX_M;
      r_k          <= 2'd0;
      r_mat_idx    <= 2'd0;
      r_base       <= '0;
      r_idx        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_dims_valid <= 1'b0;
      r_done       <= 1'b0;
      r_done_sent  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_done       <= 1'b0;
      r_dims_valid <= 1'b0;
      case (r_state)
        S_RX_M, S_RX_N, S_RX_CNT: begin
          if (w_tok_end) begin
            if ((r_state == S_RX_CNT) ? w_cnt_ok : w_dim_ok) begin
              r_err <= 1'b0;
              case (r_state)
                S_RX_M: begin
                  r_dim_m   <= r_acc[2:0];
                  r_mat_idx <= 2'd0;
                  r_state   <= S_RX_N;
                end
                S_RX_N: begin
                  r_dim_n <= r_acc[2:0];
                  if (bus.gen_mode) begin
                    r_state <= S_RX_CNT;
                  end else begin
                    r_state      <= S_WAIT_ADDR;
                    r_dims_valid <= 1'b1;
                  end
                end
                default: begin
                  r_k          <= r_acc[1:0];
                  r_state      <= S_WAIT_ADDR;
                  r_dims_valid <= 1'b1;
                end
              endcase
            end else begin
              r_err   <= 1'b1;
              r_state <= w_is_eol ? S_RX_M : S_FLUSH;
            end
          end
        end
        S_WAIT_ADDR: begin
          if (bus.addr_ready) begin
            r_base  <= bus.base_addr;
            r_idx   <= '0;
            r_state <= bus.gen_mode ? S_GEN : S_CLEAR;
          end else begin
            r_dims_valid <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_base + AW'(r_idx);
          r_wr_data <= '0;
          if (w_idx_last) begin
            r_idx   <= '0;
            r_state <= S_ELEM;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_ELEM: begin
          if (w_timeout) begin
            r_state <= r_err ? S_RX_M : S_DONE;
          end else if (w_tok_end) begin
            if (w_elem_ok) begin
              r_err     <= 1'b0;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_base + AW'(r_idx);
              r_wr_data <= DW'(w_val);
              r_idx     <= r_idx + 1'b1;
              if (w_idx_last || w_is_eol) begin
                r_state <= S_DONE;
              end
            end else begin
              r_err <= 1'b1;
            end
          end else if (bus.rx_valid && w_is_eol && !r_err) begin
            r_state <= S_DONE;
          end
        end
        S_GEN: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_base + AW'(r_idx);
          r_wr_data <= w_rand;
          if (w_idx_last) begin
            r_idx <= '0;
            if (({1'b0, r_mat_idx} + 3'd1) < {1'b0, r_k}) begin
              r_mat_idx    <= r_mat_idx + 2'd1;
              r_state      <= S_WAIT_ADDR;
              r_dims_valid <= 1'b1;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_FLUSH: begin
          if ((bus.rx_valid && w_is_eol) || w_timeout) begin
            r_err   <= 1'b0;
            r_state <= S_RX_M;
          end else begin
            r_err <= 1'b1;
          end
        end
        S_DONE: begin
          if (!r_done_sent) begin
            r_done      <= 1'b1;
            r_done_sent <= 1'b1;
          end
        end
        default: begin
          r_state <= S_RX_M;
        end
      endcase
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.dims_valid = r_dims_valid;
  assign bus.dim_m      = r_dim_m;
  assign bus.dim_n      = r_dim_n;
  assign bus.mat_idx    = r_mat_idx;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: entry, bad dims, signed data, generation,
// repeated delimiters, timeout and enable drop.
module tb_matrix_stream_loader;
  localparam int DW = 8;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  logic [DW-1:0] wq_exp[$];
  int            wq_cyc[$];
  logic [31:0]   m_lfsr;
  logic [31:0]   m_prev;

  matrix_stream_loader_if #(.DW(DW), .AW(AW)) bus ();

  matrix_stream_loader #(
    .MAX_DIM(5), .MAX_GEN(2), .ELEM_MIN(-3), .ELEM_MAX(6),
    .DW(DW), .AW(AW), .TIMEOUT(100), .LFSR_SEED(32'hACE1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR; m_prev holds the value the DUT used on the last edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 32'hACE1;
      m_prev <= 32'hACE1;
    end else begin
      m_lfsr <= {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1]};
      m_prev <= m_lfsr;
    end
  end

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
      wq_exp.push_back(DW'(int'(m_prev % 32'd10) - 3));
      wq_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic restart(input logic gm);
    bus.en = 1'b0;
    @(negedge clk);
    bus.gen_mode = gm;
    bus.en = 1'b1;
    @(negedge clk);
  endtask

  task automatic grant(input logic [AW-1:0] a);
    int t = 0;
    while (bus.dims_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (bus.dims_valid !== 1'b1) begin
      n_err++;
      $display("FAIL grant_wait: dims_valid=%b want 1", bus.dims_valid);
    end
    bus.base_addr  = a;
    bus.addr_ready = 1'b1;
    @(negedge clk);
    bus.addr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.gen_mode = 1'b0; bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    bus.base_addr = '0; bus.addr_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.dims_valid, bus.dim_m, bus.dim_n,
         bus.mat_idx, bus.done, bus.err} !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%0h dv=%b m=%0d n=%0d idx=%0d done=%b err=%b want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.dims_valid, bus.dim_m, bus.dim_n,
               bus.mat_idx, bus.done, bus.err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_user_entry();
    int b;
    int d0;
    restart(1'b0);
    b = wq_addr.size(); d0 = done_cnt;
    send_str("2 3"); send_byte(8'h0D);
    n_vec++;
    if ({bus.dims_valid, bus.dim_m, bus.dim_n, bus.err} !== {1'b1, 3'd2, 3'd3, 1'b0}) begin
      n_err++;
      $display("FAIL t1_dims: got dv=%b m=%0d n=%0d err=%b want 1 2 3 0",
               bus.dims_valid, bus.dim_m, bus.dim_n, bus.err);
    end
    grant(9'd16);
    repeat (10) @(negedge clk);
    n_vec++;
    if (wq_addr.size() - b !== 6) begin
      n_err++; $display("FAIL t1_clear_count: got %0d want 6", wq_addr.size() - b);
    end
    send_str("1 2 3 4 5 6 ");
    repeat (4) @(negedge clk);
    n_vec++;
    if (wq_addr.size() - b !== 12) begin
      n_err++; $display("FAIL t1_write_count: got %0d want 12", wq_addr.size() - b);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (wq_addr[b+i] !== 9'(16 + i) || wq_data[b+i] !== 8'h00) begin
          n_err++; $display("FAIL t1_clear_%0d: got %0d/%0h want %0d/00", i, wq_addr[b+i], wq_data[b+i], 16 + i);
        end
        n_vec++;
        if (wq_addr[b+6+i] !== 9'(16 + i) || wq_data[b+6+i] !== 8'(i + 1)) begin
          n_err++; $display("FAIL t1_elem_%0d: got %0d/%0h want %0d/%0h", i, wq_addr[b+6+i], wq_data[b+6+i], 16 + i, i + 1);
        end
      end
      n_vec++;
      if (done_cnt - d0 !== 1 || done_cyc !== wq_cyc[b+11] + 1) begin
        n_err++; $display("FAIL t1_done: got cnt=%0d cyc=%0d want 1 at %0d", done_cnt - d0, done_cyc, wq_cyc[b+11] + 1);
      end
    end
  endtask

  task automatic test_bad_dim();
    restart(1'b0);
    send_str("0 ");
    n_vec++;
    if (bus.err !== 1'b1) begin n_err++; $display("FAIL t2_err_set: got %b want 1", bus.err); end
    send_str("3 9 9");
    n_vec++;
    if (bus.err !== 1'b1) begin n_err++; $display("FAIL t2_err_flush: got %b want 1", bus.err); end
    send_byte(8'h0D);
    n_vec++;
    if ({bus.err, bus.dims_valid, bus.dim_m} !== {1'b0, 1'b0, 3'd2}) begin
      n_err++; $display("FAIL t2_flushed: got err=%b dv=%b m=%0d want 0 0 2", bus.err, bus.dims_valid, bus.dim_m);
    end
    send_str("1 1"); send_byte(8'h0D);
    n_vec++;
    if ({bus.dims_valid, bus.dim_m, bus.dim_n, bus.err} !== {1'b1, 3'd1, 3'd1, 1'b0}) begin
      n_err++; $display("FAIL t2_accept: got dv=%b m=%0d n=%0d err=%b want 1 1 1 0",
                        bus.dims_valid, bus.dim_m, bus.dim_n, bus.err);
    end
  endtask

  task automatic test_signed();
    int b;
    int d0;
    restart(1'b0);
    b = wq_addr.size(); d0 = done_cnt;
    send_str("2 2"); send_byte(8'h0D);
    grant(9'd40);
    repeat (6) @(negedge clk);
    send_str("-3 7 ");
    n_vec++;
    if (bus.err !== 1'b1) begin n_err++; $display("FAIL t3_err_7: got %b want 1", bus.err); end
    send_str("4"); send_byte(8'h0D);
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.err !== 1'b0) begin n_err++; $display("FAIL t3_err_clr: got %b want 0", bus.err); end
    n_vec++;
    if (wq_addr.size() - b !== 6) begin
      n_err++; $display("FAIL t3_count: got %0d want 6", wq_addr.size() - b);
    end else begin
      n_vec++;
      if (wq_addr[b+4] !== 9'd40 || wq_data[b+4] !== 8'hFD) begin
        n_err++; $display("FAIL t3_neg: got %0d/%0h want 40/fd", wq_addr[b+4], wq_data[b+4]);
      end
      n_vec++;
      if (wq_addr[b+5] !== 9'd41 || wq_data[b+5] !== 8'h04) begin
        n_err++; $display("FAIL t3_pos: got %0d/%0h want 41/04", wq_addr[b+5], wq_data[b+5]);
      end
    end
    n_vec++;
    if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL t3_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_gen();
    int b;
    int d0;
    restart(1'b1);
    b = wq_addr.size(); d0 = done_cnt;
    send_str("3 3 2"); send_byte(8'h0D);
    n_vec++;
    if ({bus.dims_valid, bus.mat_idx, bus.dim_m, bus.dim_n} !== {1'b1, 2'd0, 3'd3, 3'd3}) begin
      n_err++; $display("FAIL t4_first: got dv=%b idx=%0d m=%0d n=%0d want 1 0 3 3",
                        bus.dims_valid, bus.mat_idx, bus.dim_m, bus.dim_n);
    end
    grant(9'd100);
    repeat (12) @(negedge clk);
    n_vec++;
    if ({bus.dims_valid, bus.mat_idx} !== {1'b1, 2'd1} || wq_addr.size() - b !== 9) begin
      n_err++; $display("FAIL t4_second: got dv=%b idx=%0d writes=%0d want 1 1 9",
                        bus.dims_valid, bus.mat_idx, wq_addr.size() - b);
    end
    grant(9'd200);
    repeat (12) @(negedge clk);
    n_vec++;
    if (wq_addr.size() - b !== 18) begin
      n_err++; $display("FAIL t4_count: got %0d want 18", wq_addr.size() - b);
    end else begin
      for (int i = 0; i < 18; i++) begin
        n_vec++;
        if (wq_addr[b+i] !== 9'((i < 9) ? 100 + i : 191 + i) || wq_data[b+i] !== wq_exp[b+i]) begin
          n_err++; $display("FAIL t4_w%0d: got %0d/%0h want %0d/%0h", i, wq_addr[b+i], wq_data[b+i],
                            (i < 9) ? 100 + i : 191 + i, wq_exp[b+i]);
        end
      end
    end
    n_vec++;
    if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL t4_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_repeat_delim();
    restart(1'b0);
    send_str("1   2"); send_byte(8'h0D); send_byte(8'h0A);
    n_vec++;
    if ({bus.dims_valid, bus.dim_m, bus.dim_n, bus.err} !== {1'b1, 3'd1, 3'd2, 1'b0}) begin
      n_err++; $display("FAIL t5_dims: got dv=%b m=%0d n=%0d err=%b want 1 1 2 0",
                        bus.dims_valid, bus.dim_m, bus.dim_n, bus.err);
    end
  endtask

  task automatic test_timeout();
    int b;
    int seen;
    restart(1'b0);
    b = wq_addr.size(); seen = -1;
    send_str("2 2"); send_byte(8'h0D);
    grant(9'd300);
    repeat (6) @(negedge clk);
    send_str("5 ");
    for (int i = 0; i < 130 && seen < 0; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = i;
    end
    n_vec++;
    if (seen < 96 || seen > 100) begin
      n_err++; $display("FAIL t6_latency: got %0d want 96..100", seen);
    end
    n_vec++;
    if (wq_addr.size() - b !== 5) begin
      n_err++; $display("FAIL t6_count: got %0d want 5", wq_addr.size() - b);
    end else if (wq_addr[b+4] !== 9'd300 || wq_data[b+4] !== 8'h05) begin
      n_err++; $display("FAIL t6_write: got %0d/%0h want 300/05", wq_addr[b+4], wq_data[b+4]);
    end
  endtask

  task automatic test_en_drop();
    int b;
    int n;
    restart(1'b0);
    b = wq_addr.size();
    send_str("3 3"); send_byte(8'h0D);
    grant(9'd0);
    repeat (3) @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL t7_wr_en: got %b want 0", bus.wr_en); end
    n = wq_addr.size();
    repeat (5) @(negedge clk);
    n_vec++;
    if (wq_addr.size() !== n || n - b < 1 || n - b > 8) begin
      n_err++; $display("FAIL t7_writes: got %0d then %0d want 1..8 and no more", n - b, wq_addr.size() - b);
    end
    n_vec++;
    if ({bus.dims_valid, bus.dim_m, bus.dim_n} !== {1'b0, 3'd3, 3'd3}) begin
      n_err++; $display("FAIL t7_retain: got dv=%b m=%0d n=%0d want 0 3 3", bus.dims_valid, bus.dim_m, bus.dim_n);
    end
    bus.en = 1'b1;
    @(negedge clk);
    send_str("1 1"); send_byte(8'h0D);
    n_vec++;
    if ({bus.dims_valid, bus.dim_m, bus.dim_n} !== {1'b1, 3'd1, 3'd1}) begin
      n_err++; $display("FAIL t7_rx_m: got dv=%b m=%0d n=%0d want 1 1 1", bus.dims_valid, bus.dim_m, bus.dim_n);
    end
  endtask

  initial begin
    test_reset();
    test_user_entry();
    test_bad_dim();
    test_signed();
    test_gen();
    test_repeat_delim();
    test_timeout();
    test_en_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
